uart_rx_ctl: RTL

Receive-side control FSM for the FPGA debug/host UART link; the counterpart to the UART transmit controller. It synchronises the serial input pin and detects the start bit. It samples 8 data bits LSB-first on mid-bit ticks from the shared baud-rate generator and writes each good byte into the RX buffer. It also flags framing errors and buffer overruns.

---
 rtl/uart_rx_ctl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctl.sv
// uart_rx_ctl: receive-side control FSM for the debug/host UART link.
// Synchronises the serial pin, detects the start bit, enables the shared
// baud generator per frame, samples 8 data bits LSB-first on mid-bit ticks,
// and writes good bytes to the RX buffer. Flags framing errors and overruns.
// Ports:
//   clock, reset        system clock, async active-low reset
//   rx_clock_bps        mid-bit tick from baud generator (honoured only while rx_band_sig)
//   rx_pin_in           asynchronous serial line, idles high
//   rx_buf_full         RX buffer cannot accept a write this cycle
//   rx_overrun_clr      pulse clearing rx_overrun
//   rx_band_sig         enables the baud generator for the current frame
//   rx_data             last received byte
//   rx_data_valid       one-cycle write strobe to the RX buffer
//   rx_frame_err        one-cycle pulse on a bad stop bit
//   rx_overrun          sticky: good byte dropped because buffer was full
`timescale 1ns/1ps
module uart_rx_ctl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_clock_bps,
  input  logic       rx_pin_in,
  input  logic       rx_buf_full,
  input  logic       rx_overrun_clr,
  output logic       rx_band_sig,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_DATA0 = 4'd2,
    S_DATA1 = 4'd3,
    S_DATA2 = 4'd4,
    S_DATA3 = 4'd5,
    S_DATA4 = 4'd6,
    S_DATA5 = 4'd7,
    S_DATA6 = 4'd8,
    S_DATA7 = 4'd9,
    S_STOP  = 4'd10,
    S_BFREE = 4'd11
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rx_sync;
  logic                   fall_edge;
  logic                   tick;
  logic [2:0]             bit_idx;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                band_q, band_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                ovr_q, ovr_d;
  logic                ovr_set;

  // Pin synchroniser plus one delayed copy for edge detection; idle-high reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin_in};
      prev_q <= rx_sync;
    end
  end

  assign rx_sync   = sync_q[SYNC_STAGES-1];
  assign fall_edge = prev_q & ~rx_sync;
  // Ticks only count while the baud generator is enabled for this frame
  assign tick      = rx_clock_bps & band_q;
  assign bit_idx   = 3'(4'(state_q) - 4'(S_DATA0));

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      band_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      band_q  <= band_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    band_d  = band_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    ovr_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall_edge) begin
          state_d = S_START;
          band_d  = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_sync) begin
            state_d = S_DATA0;
          end else begin
            // Line back high at mid start bit: treat as a glitch
            state_d = S_IDLE;
            band_d  = 1'b0;
          end
        end
      end
      S_DATA0, S_DATA1, S_DATA2, S_DATA3,
      S_DATA4, S_DATA5, S_DATA6, S_DATA7: begin
        if (tick) begin
          shift_d[bit_idx] = rx_sync;
          state_d = (state_q == S_DATA7) ? S_STOP : state_e'(4'(state_q) + 4'd1);
        end
      end
      S_STOP: begin
        if (tick) begin
          band_d = 1'b0;
          if (rx_sync) begin
            state_d = S_IDLE;
            if (!rx_buf_full) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_set = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BFREE;
          end
        end
      end
      S_BFREE: begin
        // Wait out a break so it is not decoded as repeated frames
        if (rx_sync) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        band_d  = 1'b0;
      end
    endcase

    // Set has priority over a coincident clear
    ovr_d = ovr_q;
    if (rx_overrun_clr) ovr_d = 1'b0;
    if (ovr_set)        ovr_d = 1'b1;
  end

  assign rx_band_sig   = band_q;
  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = ovr_q;

endmodule
